marco_caller: RTL and testbench
===============================

Name: marco_caller

Overview:
- Initiator end of the MARCO/POLO UART exchange: on request, serialises "MARCO" as 8N1 UART on its own tx line, then watches a received-byte stream for the "POLO" reply.
- Reports either reply or timeout as a one-cycle pulse.
- Sits beside an existing uart_rx and baud_generator pair, and is used as a self-test partner or host-side model of the responder chip.

Parameters:
- TIMEOUT_TICKS, 19200: baud ticks to wait for a complete reply after the last stop bit (2 s at 9600 baud).
- TO_W, 15: width of the timeout counter; must hold TIMEOUT_TICKS.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- baud_tick  input  1  one-cycle pulse, once per bit period (1x baud)
- start  input  1  request an exchange; sampled only in IDLE
- rx_data  input  8  byte from uart_rx
- rx_valid  input  1  one-cycle strobe, rx_data valid
- tx  output  1  UART serial out, idle high
- busy  output  1  high while an exchange is in progress
- got_reply  output  1  one-cycle pulse, "POLO" received
- timeout  output  1  one-cycle pulse, no complete reply in time

Behaviour:
- Single clock domain clk. Reset is asynchronous and active-high on rst.
- Reset values: tx=1, busy=0, got_reply=0, timeout=0. State=IDLE. All counters and indices are 0.
- Reset asserted mid-frame forces tx=1 immediately (asynchronously). The frame is abandoned and no pulse is emitted.
- States are IDLE, START_BIT, DATA_BITS, STOP_BIT, WAIT_REPLY.
- IDLE:
  - start=1 is accepted; busy=1 from the next cycle; byte index=0; go to START_BIT.
  - tx stays 1 until the first baud_tick after acceptance.
- START_BIT:
  - On baud_tick, drive tx=0.
  - The next baud_tick moves to DATA_BITS and drives bit0.
- DATA_BITS:
  - 8 bits, LSB first, one bit per baud_tick period; a 3-bit counter selects the bit.
  - After bit7's period, the next baud_tick drives tx=1 and enters STOP_BIT.
- STOP_BIT:
  - tx=1 for one tick period.
  - On the next baud_tick: if more bytes remain, increment the index and drive the next start bit on that same tick. No idle gap between bytes.
  - Otherwise, enter WAIT_REPLY with tx=1.
- Message bytes: 0x4D 'M', 0x41 'A', 0x52 'R', 0x43 'C', 0x4F 'O'. Total frame = 5 x 10 = 50 bit periods.
- Every tx bit is held exactly from one baud_tick to the next. tx changes only in the cycle following a baud_tick.
- WAIT_REPLY matcher:
  - Expected sequence is 0x50 'P', 0x4F 'O', 0x4C 'L', 0x4F 'O'; match index 0..3.
  - rx_valid with byte equal to the expected byte: index+1.
  - Mismatch: index=1 if byte==0x50, else index=0.
  - 4th match: got_reply=1 for one cycle, busy=0, go to IDLE.
- Timeout:
  - The counter clears on entry to WAIT_REPLY and increments on each baud_tick there.
  - When it reaches TIMEOUT_TICKS: timeout=1 for one cycle, busy=0, go to IDLE.
- Simultaneous final match and timeout in the same cycle: got_reply wins and timeout is not pulsed.
- rx_valid outside WAIT_REPLY is ignored; the matcher index is cleared on entry to WAIT_REPLY.
- start while busy is ignored and not queued.
- start in the same cycle that got_reply or timeout pulses is ignored. The earliest restart is the next cycle in IDLE.
- Pulses are registered outputs. got_reply and timeout are never high simultaneously.

Optional Feature:
- Macro MARCO_CALLER_CRLF_EN.
- Defined: the message is 7 bytes, "MARCO" followed by 0x0D 0x0A. The frame is 70 bit periods; everything else is unchanged.
- Undefined: the message is 5 bytes as above; no CR/LF logic is present.

Test Plan:
- Reset then idle: rst pulse, no start, 200 baud ticks -> tx=1 throughout; busy, got_reply, timeout all 0.
- Frame shape: baud_tick every 8 clk, start pulse -> tx sequence per tick is 0,1,0,1,1,0,0,1,0,1 for 0x4D, followed by 0x41, 0x52, 0x43, 0x4F frames. 50 tick periods with no gaps. busy=1 throughout.
- Reply: after the frame, drive rx bytes 0x50,0x4F,0x4C,0x4F -> got_reply high exactly 1 cycle after the last rx_valid; busy=0; timeout never asserted.
- Restart-on-P: rx bytes 0x50,0x50,0x4F,0x4C,0x4F -> got_reply pulses once. Also 0x50,0x4F,0x58,0x4C,0x4F -> no reply; timeout pulses after TIMEOUT_TICKS (set to 20).
- Timeout and collision:
  - TIMEOUT_TICKS=20, no rx -> timeout pulse on the 20th tick after the last stop bit.
  - Final 0x4F rx_valid coincident with the 20th tick -> got_reply=1, timeout=0.
- Abuse:
  - start held high for the whole frame -> exactly one frame sent; a second frame begins only after returning to IDLE.
  - rst asserted mid-byte -> tx=1 same cycle; busy=0; no pulses.
  - With MARCO_CALLER_CRLF_EN defined -> 0x0D and 0x0A frames follow 0x4F before WAIT_REPLY.

Source files
------------

// File: rtl/marco_caller.sv
// marco_caller: transmits "MARCO" as 8N1 UART, then waits for a "POLO" reply or a timeout.
// Define MARCO_CALLER_CRLF_EN to append CR LF (0x0D 0x0A) to the transmitted message.
module marco_caller #(
    parameter int unsigned TIMEOUT_TICKS = 19200,
    parameter int unsigned TO_W          = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud_tick,
    input  logic       start,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       tx,
    output logic       busy,
    output logic       got_reply,
    output logic       timeout
);

`ifdef MARCO_CALLER_CRLF_EN
    localparam int unsigned MSG_LEN = 7;
`else
    localparam int unsigned MSG_LEN = 5;
`endif
    localparam logic [2:0] LAST_BYTE = 3'(MSG_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        START_BIT,
        DATA_BITS,
        STOP_BIT,
        WAIT_REPLY
    } state_t;

    state_t          state;
    logic [2:0]      byte_idx;
    logic [2:0]      bit_idx;
    logic [1:0]      match_idx;
    logic            start_driven;
    logic [TO_W-1:0] to_cnt;

    logic [7:0]      cur_byte;
    logic [7:0]      exp_byte;
    logic [2:0]      next_bit;
    logic            final_match;
    logic            to_done;

    // Outgoing message ROM
    always_comb begin
        cur_byte = 8'h00;
        case (byte_idx)
            3'd0:    cur_byte = 8'h4D;
            3'd1:    cur_byte = 8'h41;
            3'd2:    cur_byte = 8'h52;
            3'd3:    cur_byte = 8'h43;
            3'd4:    cur_byte = 8'h4F;
`ifdef MARCO_CALLER_CRLF_EN
            3'd5:    cur_byte = 8'h0D;
            3'd6:    cur_byte = 8'h0A;
`endif
            default: cur_byte = 8'h00;
        endcase
    end

    // Expected reply byte at the current match position
    always_comb begin
        exp_byte = 8'h50;
        case (match_idx)
            2'd0:    exp_byte = 8'h50;
            2'd1:    exp_byte = 8'h4F;
            2'd2:    exp_byte = 8'h4C;
            default: exp_byte = 8'h4F;
        endcase
    end

    assign next_bit    = bit_idx + 3'd1;
    assign final_match = rx_valid && (rx_data == exp_byte) && (match_idx == 2'd3);
    assign to_done     = baud_tick && (to_cnt == TO_W'(TIMEOUT_TICKS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            byte_idx     <= 3'd0;
            bit_idx      <= 3'd0;
            match_idx    <= 2'd0;
            start_driven <= 1'b0;
            to_cnt       <= '0;
            tx           <= 1'b1;
            busy         <= 1'b0;
            got_reply    <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            got_reply <= 1'b0;
            timeout   <= 1'b0;
            case (state)
                IDLE: begin
                    // A start coinciding with a result pulse is dropped
                    if (start && !got_reply && !timeout) begin
                        state        <= START_BIT;
                        busy         <= 1'b1;
                        byte_idx     <= 3'd0;
                        bit_idx      <= 3'd0;
                        start_driven <= 1'b0;
                    end
                end
                START_BIT: begin
                    if (baud_tick) begin
                        if (!start_driven) begin
                            tx           <= 1'b0;
                            start_driven <= 1'b1;
                        end else begin
                            tx      <= cur_byte[0];
                            bit_idx <= 3'd0;
                            state   <= DATA_BITS;
                        end
                    end
                end
                DATA_BITS: begin
                    if (baud_tick) begin
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP_BIT;
                        end else begin
                            bit_idx <= next_bit;
                            tx      <= cur_byte[next_bit];
                        end
                    end
                end
                STOP_BIT: begin
                    if (baud_tick) begin
                        if (byte_idx != LAST_BYTE) begin
                            // Back-to-back: next start bit goes out on this same tick
                            byte_idx     <= byte_idx + 3'd1;
                            tx           <= 1'b0;
                            start_driven <= 1'b1;
                            state        <= START_BIT;
                        end else begin
                            to_cnt    <= '0;
                            match_idx <= 2'd0;
                            state     <= WAIT_REPLY;
                        end
                    end
                end
                WAIT_REPLY: begin
                    if (baud_tick) begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                    if (rx_valid) begin
                        if (rx_data == exp_byte) begin
                            match_idx <= match_idx + 2'd1;
                        end else begin
                            match_idx <= (rx_data == 8'h50) ? 2'd1 : 2'd0;
                        end
                    end
                    if (final_match) begin
                        got_reply <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else if (to_done) begin
                        timeout <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_marco_caller.sv
// tb_marco_caller: table-driven, hand-written and randomized checks of marco_caller
// against a transaction-level model (bit list of the frame, last-four-bytes reply match).
module tb_marco_caller;
    localparam int unsigned TO_TICKS = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic       baud_tick;
    logic       start;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx;
    logic       busy;
    logic       got_reply;
    logic       timeout;

    marco_caller #(.TIMEOUT_TICKS(TO_TICKS), .TO_W(15)) dut (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .start(start),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .tx(tx), .busy(busy), .got_reply(got_reply), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    typedef enum int {M_IDLE, M_SEND, M_WAIT} mmode_t;
    mmode_t     m_mode;
    int         m_k;
    int         m_w;
    logic       m_tx, m_busy, m_got, m_to;
    logic [7:0] m_hist[$];
    logic       m_bits[$];
    logic [7:0] msg[$];

    int   gap   = 8;
    int   phase = 0;
    logic cap[$];
    int   seen_got, seen_to;

    typedef struct {
        int         n;
        logic [7:0] b[8];
        int         rx_gap;
        int         exp_got;
        int         exp_to;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_k = 0; m_w = 0;
        m_tx = 1'b1; m_busy = 1'b0; m_got = 1'b0; m_to = 1'b0;
        m_hist.delete();
    endtask

    task automatic model_step(input logic tk, input logic rv, input logic [7:0] rd, input logic st);
        logic pulse_prev;
        logic reply;
        pulse_prev = m_got | m_to;
        reply = 1'b0;
        m_got = 1'b0;
        m_to  = 1'b0;
        case (m_mode)
            M_IDLE: if (st && !pulse_prev) begin
                m_mode = M_SEND; m_k = 0; m_busy = 1'b1;
            end
            M_SEND: if (tk) begin
                if (m_k < m_bits.size()) begin
                    m_tx = m_bits[m_k];
                    m_k++;
                end else begin
                    m_mode = M_WAIT; m_w = 0; m_hist.delete();
                end
            end
            default: begin
                if (rv) begin
                    m_hist.push_back(rd);
                    if (m_hist.size() > 4) void'(m_hist.pop_front());
                    reply = (m_hist.size() == 4) && m_hist[0] == 8'h50 && m_hist[1] == 8'h4F
                            && m_hist[2] == 8'h4C && m_hist[3] == 8'h4F;
                end
                if (tk) m_w++;
                if (reply) begin
                    m_got = 1'b1; m_busy = 1'b0; m_mode = M_IDLE;
                end else if (tk && m_w == int'(TO_TICKS)) begin
                    m_to = 1'b1; m_busy = 1'b0; m_mode = M_IDLE;
                end
            end
        endcase
    endtask

    // One clock: drive at negedge, sample #1 after posedge, return at next negedge
    task automatic step(input logic rv, input logic [7:0] rd, input logic st);
        logic tk;
        logic sending;
        tk = ((phase % gap) == gap - 1);
        phase++;
        baud_tick = tk; rx_valid = rv; rx_data = rd; start = st;
        sending = (m_mode == M_SEND) && (m_k < m_bits.size());
        model_step(tk, rv, rd, st);
        @(posedge clk);
        #1;
        check("tx", 32'(tx), 32'(m_tx));
        check("busy", 32'(busy), 32'(m_busy));
        check("got_reply", 32'(got_reply), 32'(m_got));
        check("timeout", 32'(timeout), 32'(m_to));
        if (tk && sending) cap.push_back(tx);
        seen_got += int'(got_reply);
        seen_to  += int'(timeout);
        @(negedge clk);
        baud_tick = 1'b0; rx_valid = 1'b0; start = 1'b0;
    endtask

    task automatic wait_mode(input mmode_t target, input int lim_in, input logic st);
        int lim;
        lim = 0;
        while (m_mode != target && lim < lim_in) begin
            step(1'b0, 8'h00, st);
            lim++;
        end
        check("wait_bound", 32'(lim < lim_in), 32'd1);
    endtask

    task automatic wait_idle();
        wait_mode(M_IDLE, 4000, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int exp10[10];
        exp10 = '{0, 1, 0, 1, 1, 0, 0, 1, 0, 1};
        cap.delete(); seen_got = 0; seen_to = 0;
        step(1'b0, 8'h00, 1'b1);
        wait_mode(M_WAIT, 4000, 1'b0);
        check($sformatf("vec%0d_frame_len", idx), 32'(cap.size()), 32'(msg.size() * 10));
        if (cap.size() >= 10)
            for (int i = 0; i < 10; i++)
                check($sformatf("vec%0d_m_bit%0d", idx, i), 32'(cap[i]), 32'(exp10[i]));
        for (int j = 0; j < v.n; j++) begin
            step(1'b1, v.b[j], 1'b0);
            if (j == v.n - 1)
                check($sformatf("vec%0d_reply_latency", idx), 32'(got_reply), 32'(v.exp_got));
            for (int g = 1; g < v.rx_gap; g++) step(1'b0, 8'h00, 1'b0);
        end
        wait_idle();
        check($sformatf("vec%0d_got_count", idx), 32'(seen_got), 32'(v.exp_got));
        check($sformatf("vec%0d_to_count", idx), 32'(seen_to), 32'(v.exp_to));
    endtask

    initial begin
        int lim;
        int low_cnt;
        logic [7:0] pool[4];
        logic [7:0] stream[$];

        msg = '{8'h4D, 8'h41, 8'h52, 8'h43, 8'h4F};
`ifdef MARCO_CALLER_CRLF_EN
        msg.push_back(8'h0D);
        msg.push_back(8'h0A);
`endif
        foreach (msg[i]) begin
            logic [7:0] by;
            by = msg[i];
            m_bits.push_back(1'b0);
            for (int b = 0; b < 8; b++) m_bits.push_back(by[b]);
            m_bits.push_back(1'b1);
        end

        vecs[0] = '{0, '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3, 0, 1};
        vecs[1] = '{4, '{8'h50, 8'h4F, 8'h4C, 8'h4F, 8'h00, 8'h00, 8'h00, 8'h00}, 3, 1, 0};
        vecs[2] = '{5, '{8'h50, 8'h50, 8'h4F, 8'h4C, 8'h4F, 8'h00, 8'h00, 8'h00}, 2, 1, 0};
        vecs[3] = '{5, '{8'h50, 8'h4F, 8'h58, 8'h4C, 8'h4F, 8'h00, 8'h00, 8'h00}, 3, 0, 1};
        vecs[4] = '{8, '{8'h58, 8'h50, 8'h4F, 8'h4C, 8'h50, 8'h4F, 8'h4C, 8'h4F}, 1, 1, 0};
        vecs[5] = '{3, '{8'h50, 8'h4F, 8'h4C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 4, 0, 1};

        rst = 1'b1; baud_tick = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_got", 32'(got_reply), 32'd0);
        check("reset_to", 32'(timeout), 32'd0);
        rst = 1'b0;

        // Idle with ticks and no start
        repeat (200 * gap) step(1'b0, 8'h00, 1'b0);

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Final match lands on the same tick that would expire the timeout
        seen_got = 0; seen_to = 0;
        step(1'b0, 8'h00, 1'b1);
        wait_mode(M_WAIT, 4000, 1'b0);
        step(1'b1, 8'h50, 1'b0);
        step(1'b1, 8'h4F, 1'b0);
        step(1'b1, 8'h4C, 1'b0);
        lim = 0;
        while (!(m_w == int'(TO_TICKS) - 1 && (phase % gap) == gap - 1) && lim < 1000) begin
            step(1'b0, 8'h00, 1'b0);
            lim++;
        end
        check("collide_align", 32'(lim < 1000), 32'd1);
        step(1'b1, 8'h4F, 1'b0);
        check("collide_got", 32'(got_reply), 32'd1);
        check("collide_to", 32'(timeout), 32'd0);
        wait_idle();
        check("collide_to_count", 32'(seen_to), 32'd0);

        // Start held high: one frame, restart only after returning to idle
        seen_got = 0; seen_to = 0;
        step(1'b0, 8'h00, 1'b1);
        wait_mode(M_WAIT, 4000, 1'b1);
        lim = 0;
        while (!timeout && lim < 2000) begin
            step(1'b0, 8'h00, 1'b1);
            lim++;
        end
        check("held_timeout_seen", 32'(timeout), 32'd1);
        low_cnt = 1;
        lim = 0;
        while (lim < 10) begin
            step(1'b0, 8'h00, 1'b1);
            lim++;
            if (busy) break;
            low_cnt++;
        end
        check("held_idle_gap", 32'(low_cnt), 32'd2);
        check("held_restart", 32'(busy), 32'd1);
        wait_idle();

        // Async reset in the middle of a byte
        step(1'b0, 8'h00, 1'b1);
        lim = 0;
        while (!(m_mode == M_SEND && m_k > 3 && m_tx == 1'b0) && lim < 1000) begin
            step(1'b0, 8'h00, 1'b0);
            lim++;
        end
        check("midrst_tx_low", 32'(tx), 32'd0);
        #2 rst = 1'b1;
        #1;
        check("midrst_tx", 32'(tx), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_pulses", 32'(got_reply | timeout), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        seen_got = 0; seen_to = 0;
        repeat (300) step(1'b0, 8'h00, 1'b0);
        check("midrst_no_pulse", 32'(seen_got + seen_to), 32'd0);

        // Randomized exchanges with random tick rates and noise
        pool = '{8'h50, 8'h4F, 8'h4C, 8'h58};
        for (int it = 0; it < 25; it++) begin
            gap = int'($urandom_range(1, 10));
            phase = 0;
            repeat ($urandom_range(0, 5)) step(1'($urandom % 2), 8'($urandom), 1'b0);
            step(1'b0, 8'h00, 1'b1);
            lim = 0;
            while (m_mode != M_WAIT && lim < 4000) begin
                step(1'($urandom % 4 == 0), 8'($urandom), 1'($urandom % 8 == 0));
                lim++;
            end
            check("rand_reach_wait", 32'(lim < 4000), 32'd1);
            stream.delete();
            repeat ($urandom_range(0, 3)) stream.push_back(pool[$urandom % 4]);
            if ($urandom % 2 == 1) begin
                stream.push_back(8'h50); stream.push_back(8'h4F);
                stream.push_back(8'h4C); stream.push_back(8'h4F);
            end
            foreach (stream[j]) begin
                if (m_mode != M_WAIT) break;
                step(1'b1, stream[j], 1'($urandom % 2));
                repeat ($urandom_range(0, 3))
                    if (m_mode == M_WAIT) step(1'b0, 8'h00, 1'($urandom % 2));
            end
            wait_idle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
